// File: rtl/fle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fle_pkg
//  Description : Shared types and sizing helpers for the fracturable logic
//                element: FSM state encoding, config-size functions and the
//                offsets of the mode fields that follow the truth table.
//  Revision    : 1.0 - initial release
// ============================================================================
package fle_pkg;

    // Programming FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        RUN  = 2'd2
    } fle_state_t;

    // Total config bits: truth table plus frac, regsel A, regsel B.
    function automatic int cfg_bits(input int k);
        return (1 << k) + 3;
    endfunction

    // Address width needed to reach every config bit.
    function automatic int addr_w(input int k);
        return $clog2(cfg_bits(k));
    endfunction

    // Mode fields sit directly above the truth table.
    function automatic int frac_ofs(input int k);
        return (1 << k);
    endfunction

    function automatic int rega_ofs(input int k);
        return (1 << k) + 1;
    endfunction

    function automatic int regb_ofs(input int k);
        return (1 << k) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ltile_lut_frac.sv
`default_nettype none
// ============================================================================
//  Module      : ltile_lut_frac
//  Description : Combinational fracturable LUT. Whole mode reads the full
//                truth table with all LUT_K inputs; frac mode splits it into
//                a lower half (output A) and an upper half (output B), both
//                addressed by the low LUT_K-1 inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module ltile_lut_frac #(
    parameter int LUT_K = 4
) (
    input  logic [(1 << LUT_K)-1:0] truth,
    input  logic                    frac,
    input  logic [LUT_K-1:0]        fle_in,
    output logic                    lut_a,
    output logic                    lut_b
);

    logic [LUT_K-2:0] w_lo_idx;

    assign w_lo_idx = fle_in[LUT_K-2:0];

    // Select whole-LUT or split-LUT lookup; the top input is unused when split.
    always_comb begin
        lut_a = truth[fle_in];
        lut_b = 1'b0;
        if (frac) begin
            lut_a = truth[{1'b0, w_lo_idx}];
            lut_b = truth[{1'b1, w_lo_idx}];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ltile_clb_fle_frac.sv
`default_nettype none
// ============================================================================
//  Module      : ltile_clb_fle_frac
//  Description : Fracturable logic element for the CLB tile. Holds the
//                serially programmed config bits, the programming FSM that
//                locks them on prog_done, two user FFs and the per-output
//                register/bypass muxes.
//                Optional feature macro: FLE_CFG_READBACK_EN adds a registered
//                config readback port cfg_rdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module ltile_clb_fle_frac
    import fle_pkg::*;
#(
    parameter  int   LUT_K      = 4,
    parameter  logic FF_RST_VAL = 1'b0,
    localparam int   CFG_BITS   = cfg_bits(LUT_K),
    localparam int   ADDR_W     = addr_w(LUT_K)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic [LUT_K-1:0]  fle_in,
    input  logic              enable,
    input  logic [ADDR_W-1:0] address,
    input  logic              data_in,
    input  logic              prog_done,
    output logic              cfg_ready,
    output logic [1:0]        fle_out
`ifdef FLE_CFG_READBACK_EN
    ,
    output logic              cfg_rdata
`endif
);

    localparam int TT_BITS  = 1 << LUT_K;
    localparam int FRAC_OFS = frac_ofs(LUT_K);
    localparam int REGA_OFS = rega_ofs(LUT_K);
    localparam int REGB_OFS = regb_ofs(LUT_K);

    logic [CFG_BITS-1:0] r_cfg;
    fle_state_t          r_state;
    fle_state_t          w_state_nxt;
    logic [1:0]          r_ff;
    logic                w_wr;
    logic                w_run;
    logic                w_lut_a;
    logic                w_lut_b;

    assign w_run = (r_state == RUN);
    // Writes are accepted until the configuration is locked in RUN.
    assign w_wr  = enable && !w_run;

    // Config store: out-of-range addresses match no bit, so they are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < CFG_BITS; i++) begin
                if (address == ADDR_W'(i)) begin
                    r_cfg[i] <= data_in;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: prog_done wins over enable, RUN is sticky until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (prog_done) begin
                    w_state_nxt = RUN;
                end else if (enable) begin
                    w_state_nxt = PROG;
                end
            end
            PROG: begin
                if (prog_done) begin
                    w_state_nxt = RUN;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    ltile_lut_frac #(
        .LUT_K (LUT_K)
    ) u_lut (
        .truth  (r_cfg[TT_BITS-1:0]),
        .frac   (r_cfg[FRAC_OFS]),
        .fle_in (fle_in),
        .lut_a  (w_lut_a),
        .lut_b  (w_lut_b)
    );

    // User FFs: reset beats set beats capture; they only track the LUTs in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ff <= {2{FF_RST_VAL}};
        end else if (set) begin
            r_ff <= 2'b11;
        end else if (w_run) begin
            r_ff <= {w_lut_b, w_lut_a};
        end else begin
            r_ff <= {2{FF_RST_VAL}};
        end
    end

    assign cfg_ready  = w_run;
    assign fle_out[0] = w_run & (r_cfg[REGA_OFS] ? r_ff[0] : w_lut_a);
    assign fle_out[1] = w_run & (r_cfg[REGB_OFS] ? r_ff[1] : w_lut_b);

`ifdef FLE_CFG_READBACK_EN
    logic r_cfg_rdata;

    // Registered readback of the addressed bit; out-of-range reads return 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_rdata <= 1'b0;
        end else begin
            r_cfg_rdata <= 1'b0;
            for (int i = 0; i < CFG_BITS; i++) begin
                if (address == ADDR_W'(i)) begin
                    r_cfg_rdata <= r_cfg[i];
                end
            end
        end
    end

    assign cfg_rdata = r_cfg_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ltile_clb_fle_frac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ltile_clb_fle_frac
//  Description : Self-checking bench for ltile_clb_fle_frac (LUT_K=4): a
//                hand-written vector table, directed multi-cycle sequences
//                and randomized stimulus against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ltile_clb_fle_frac;

    localparam int K  = 4;
    localparam int NB = (1 << K) + 3;

    logic       clk = 1'b0;
    logic       reset, set, enable, data_in, prog_done;
    logic [3:0] fle_in;
    logic [4:0] address;
    logic       cfg_ready;
    logic [1:0] fle_out;
`ifdef FLE_CFG_READBACK_EN
    logic       cfg_rdata;
`endif

    always #5 clk = ~clk;

    ltile_clb_fle_frac #(
        .LUT_K      (K),
        .FF_RST_VAL (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .set       (set),
        .fle_in    (fle_in),
        .enable    (enable),
        .address   (address),
        .data_in   (data_in),
        .prog_done (prog_done),
        .cfg_ready (cfg_ready),
        .fle_out   (fle_out)
`ifdef FLE_CFG_READBACK_EN
        ,
        .cfg_rdata (cfg_rdata)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state.
    bit m_cfg [NB];
    int m_state;        // 0 idle, 1 programming, 2 running
    bit m_ff  [2];
    bit m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // LUT outputs from the truth-table rules, using the current fle_in.
    task automatic m_luts(output bit a, output bit b);
        int idx;
        idx = int'(fle_in);
        if (m_cfg[NB-3]) begin
            a = m_cfg[idx % 8];
            b = m_cfg[8 + (idx % 8)];
        end else begin
            a = m_cfg[idx];
            b = 1'b0;
        end
    endtask

    task automatic m_out(output logic [1:0] o);
        bit a, b;
        m_luts(a, b);
        if (m_state != 2) o = 2'b00;
        else begin
            o[0] = m_cfg[NB-2] ? m_ff[0] : a;
            o[1] = m_cfg[NB-1] ? m_ff[1] : b;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NB; i++) m_cfg[i] = 1'b0;
        m_state = 0;
        m_ff[0] = 1'b0;
        m_ff[1] = 1'b0;
        m_rd    = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic m_step();
        bit a, b;
        int ad;
        m_luts(a, b);
        ad = int'(address);
        if (reset) begin
            m_reset();
        end else begin
            m_rd = (ad < NB) ? m_cfg[ad] : 1'b0;
            if (set) begin
                m_ff[0] = 1'b1; m_ff[1] = 1'b1;
            end else if (m_state == 2) begin
                m_ff[0] = a; m_ff[1] = b;
            end else begin
                m_ff[0] = 1'b0; m_ff[1] = 1'b0;
            end
            if (m_state != 2 && enable && ad < NB) m_cfg[ad] = data_in;
            if (m_state != 2 && prog_done) m_state = 2;
            else if (m_state == 0 && enable) m_state = 1;
        end
    endtask

    // One cycle: drive, compare against the model at negedge, then clock.
    task automatic cyc(input bit rs, input bit st, input bit en, input int ad,
                       input bit din, input bit dn, input int fi,
                       output logic rdy, output logic [1:0] o);
        logic [1:0] eo;
        reset = rs; set = st; enable = en; address = 5'(ad);
        data_in = din; prog_done = dn; fle_in = 4'(fi);
        @(negedge clk);
        m_out(eo);
        rdy = cfg_ready;
        o   = fle_out;
        chk("model_ready", 32'(cfg_ready), 32'(m_state == 2));
        chk("model_out", 32'(fle_out), 32'(eo));
`ifdef FLE_CFG_READBACK_EN
        chk("model_rdata", 32'(cfg_rdata), 32'(m_rd));
`endif
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic wr(input int ad, input bit din);
        logic r; logic [1:0] o;
        cyc(0, 0, 1, ad, din, 0, 0, r, o);
    endtask

    typedef struct {
        bit       rs, st, en;
        int       ad;
        bit       din, dn;
        int       fi;
        bit       chk;
        bit       er;
        bit [1:0] eo;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic       r;
        logic [1:0] o;

        // AND4 programming, evaluation, lock and reset.
        tbl[0] = '{1, 0, 0,  0, 0, 0,  0, 0, 0, 2'b00};
        tbl[1] = '{0, 0, 0,  0, 0, 0,  0, 1, 0, 2'b00};
        tbl[2] = '{0, 0, 1, 15, 1, 0,  0, 1, 0, 2'b00};
        tbl[3] = '{0, 0, 0,  0, 0, 1,  0, 1, 0, 2'b00};
        tbl[4] = '{0, 0, 0,  0, 0, 0, 15, 1, 1, 2'b01};
        tbl[5] = '{0, 0, 0,  0, 0, 0,  7, 1, 1, 2'b00};
        tbl[6] = '{0, 0, 1, 15, 0, 0, 15, 1, 1, 2'b01};
        tbl[7] = '{0, 0, 0,  0, 0, 0, 15, 1, 1, 2'b01};
        tbl[8] = '{1, 0, 0,  0, 0, 0, 15, 1, 1, 2'b01};
        tbl[9] = '{0, 0, 0,  0, 0, 0, 15, 1, 0, 2'b00};

        reset = 1; set = 0; enable = 0; address = '0; data_in = 0;
        prog_done = 0; fle_in = '0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].rs, tbl[i].st, tbl[i].en, tbl[i].ad, tbl[i].din,
                tbl[i].dn, tbl[i].fi, r, o);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_ready", i), 32'(r), 32'(tbl[i].er));
                chk($sformatf("tbl%0d_out", i), 32'(o), 32'(tbl[i].eo));
            end
        end

        // Registered path on output A, set and reset+set.
        cyc(1, 0, 0, 0, 0, 0, 0, r, o);
        wr(15, 1);
        wr(17, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, r, o);
        cyc(0, 0, 0, 0, 0, 0, 15, r, o);
        chk("reg_same_cycle", 32'(o[0]), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, r, o);
        chk("reg_next_cycle", 32'(o[0]), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, r, o);
        chk("reg_low", 32'(o[0]), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, r, o);
        cyc(0, 0, 0, 0, 0, 0, 0, r, o);
        chk("set_forces_one", 32'(o[0]), 32'd1);
        cyc(1, 1, 0, 0, 0, 0, 0, r, o);
        cyc(0, 0, 0, 0, 0, 0, 0, r, o);
        chk("rst_set_ready", 32'(r), 32'd0);
        chk("rst_set_out", 32'(o), 32'd0);

        // Frac mode: A = lower half, B = upper half, fle_in[3] ignored.
        cyc(1, 0, 0, 0, 0, 0, 0, r, o);
        wr(16, 1);
        wr(1, 1);
        wr(9, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, r, o);
        cyc(0, 0, 0, 0, 0, 0, 4'b0001, r, o);
        chk("frac_11", 32'(o), 32'd3);
        cyc(0, 0, 0, 0, 0, 0, 4'b1001, r, o);
        chk("frac_top_ignored", 32'(o), 32'd3);
        cyc(0, 0, 0, 0, 0, 0, 4'b1000, r, o);
        chk("frac_00", 32'(o), 32'd0);

        // Out-of-range write leaves the config all-zero.
        cyc(1, 0, 0, 0, 0, 0, 0, r, o);
        wr(31, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, r, o);
        for (int f = 0; f < 16; f++) begin
            cyc(0, 0, 0, 0, 0, 0, f, r, o);
            chk("oor_zero_cfg", 32'(o), 32'd0);
        end

        // Reset mid-programming discards all prior writes.
        cyc(1, 0, 0, 0, 0, 0, 0, r, o);
        for (int a = 0; a < 8; a++) wr(a * 2, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, r, o);
        cyc(0, 0, 0, 0, 0, 0, 0, r, o);
        chk("midrst_ready", 32'(r), 32'd0);
        chk("midrst_out", 32'(o), 32'd0);
`ifdef FLE_CFG_READBACK_EN
        for (int a = 0; a < 32; a++) begin
            cyc(0, 0, 0, a, 0, 0, 0, r, o);
            if (a > 0) chk("midrst_rdata", 32'(cfg_rdata), 32'd0);
        end
`endif
        cyc(0, 0, 0, 0, 0, 1, 0, r, o);
        for (int f = 0; f < 16; f += 5) begin
            cyc(0, 0, 0, 0, 0, 0, f, r, o);
            chk("midrst_cfg_zero", 32'(o), 32'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom % 80) == 0, ($urandom % 16) == 0, $urandom % 2,
                $urandom % 32, $urandom % 2, ($urandom % 30) == 0,
                $urandom % 16, r, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
